// File: rtl/register_pair_file_pkg.sv
// Shared CPU register-file constants: default byte width, word width and the
// architectural pair indices used by the datapath.
package register_pair_file_pkg;
  localparam int DEF_BYTE_W = 8;
  localparam int WORD_W     = 2 * DEF_BYTE_W;

  localparam int PAIR_BC = 0;
  localparam int PAIR_DE = 1;
  localparam int PAIR_HL = 2;
  localparam int PAIR_SP = 3;
endpackage

// File: rtl/register_pair_stepper.sv
// Combinational +/-1 on one register-pair word, with a wrap flag for
// all-ones increments and zero decrements.
module register_pair_stepper #(
  parameter int WORD_W = 16
) (
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_dec,
  output logic [WORD_W-1:0] o_word,
  output logic              o_wrap
);
  always_comb begin
    o_word = i_dec ? (i_word - WORD_W'(1)) : (i_word + WORD_W'(1));
    o_wrap = i_dec ? (i_word == '0) : (&i_word);
  end
endmodule

// File: rtl/register_pair_file.sv
// PAIRS byte-addressable register pairs with byte/word writes, two registered
// byte-read ports, two combinational word-read ports and a pair stepper.
module register_pair_file
  import register_pair_file_pkg::*;
#(
  parameter  int BYTE_W  = DEF_BYTE_W,
  parameter  int PAIRS   = 4,
  localparam int PAIR_AW = $clog2(PAIRS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PAIR_AW-1:0]    wr_sel,
  input  logic                  wr_l,
  input  logic                  wr_h,
  input  logic                  wr_w,
  input  logic [BYTE_W-1:0]     din_b,
  input  logic [2*BYTE_W-1:0]   din_w,
  input  logic [PAIR_AW-1:0]    step_sel,
  input  logic                  inc,
  input  logic                  dec,
  input  logic [PAIR_AW-1:0]    rdA_sel,
  input  logic                  rdA_hi,
  input  logic                  rdA_en,
  input  logic [PAIR_AW-1:0]    rdB_sel,
  input  logic                  rdB_hi,
  input  logic                  rdB_en,
  output logic [BYTE_W-1:0]     rdA_data,
  output logic                  rdA_valid,
  output logic [BYTE_W-1:0]     rdB_data,
  output logic                  rdB_valid,
  input  logic [PAIR_AW-1:0]    wA_sel,
  input  logic [PAIR_AW-1:0]    wB_sel,
  output logic [2*BYTE_W-1:0]   wA_data,
  output logic [2*BYTE_W-1:0]   wB_data,
  output logic                  step_wrap
);
  localparam int WW = 2 * BYTE_W;

  logic [WW-1:0] r_pair [PAIRS];

  logic          w_wr_any;
  logic          w_wr_ok;
  logic          w_step_ok;
  logic          w_step_go;
  logic [WW-1:0] w_step_src;
  logic [WW-1:0] w_step_res;
  logic          w_step_wrap;

  function automatic logic f_in_range(input logic [PAIR_AW-1:0] sel);
    return (int'(sel) < PAIRS);
  endfunction

  function automatic logic [WW-1:0] f_word(input logic [PAIR_AW-1:0] sel);
    return f_in_range(sel) ? r_pair[sel] : '0;
  endfunction

  function automatic logic [BYTE_W-1:0] f_byte(input logic [PAIR_AW-1:0] sel,
                                               input logic hi);
    logic [WW-1:0] w;
    w = f_word(sel);
    return hi ? w[WW-1:BYTE_W] : w[BYTE_W-1:0];
  endfunction

  // A write to the stepped pair in the same cycle takes precedence.
  always_comb begin
    w_wr_any   = wr_l | wr_h | wr_w;
    w_wr_ok    = w_wr_any && f_in_range(wr_sel);
    w_step_ok  = f_in_range(step_sel);
    w_step_src = f_word(step_sel);
    w_step_go  = (inc ^ dec) && w_step_ok && !(w_wr_any && (wr_sel == step_sel));
  end

  register_pair_stepper #(.WORD_W(WW)) u_stepper (
    .i_word (w_step_src),
    .i_dec  (dec),
    .o_word (w_step_res),
    .o_wrap (w_step_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PAIRS; i++) r_pair[i] <= '0;
      rdA_data  <= '0;
      rdA_valid <= 1'b0;
      rdB_data  <= '0;
      rdB_valid <= 1'b0;
      step_wrap <= 1'b0;
    end else begin
      for (int i = 0; i < PAIRS; i++) begin
        if (w_wr_ok && (wr_sel == PAIR_AW'(i))) begin
          if (wr_l)      r_pair[i][BYTE_W-1:0] <= din_b;
          else if (wr_w) r_pair[i][BYTE_W-1:0] <= din_w[BYTE_W-1:0];
          if (wr_h)      r_pair[i][WW-1:BYTE_W] <= din_b;
          else if (wr_w) r_pair[i][WW-1:BYTE_W] <= din_w[WW-1:BYTE_W];
        end else if (w_step_go && (step_sel == PAIR_AW'(i))) begin
          r_pair[i] <= w_step_res;
        end
      end
      step_wrap <= w_step_go & w_step_wrap;
      // Reads sample the pre-edge contents, so no write-through.
      rdA_valid <= rdA_en;
      rdA_data  <= rdA_en ? f_byte(rdA_sel, rdA_hi) : '0;
      rdB_valid <= rdB_en;
      rdB_data  <= rdB_en ? f_byte(rdB_sel, rdB_hi) : '0;
    end
  end

  assign wA_data = f_word(wA_sel);
  assign wB_data = f_word(wB_sel);
endmodule

// File: tb/tb_register_pair_file.sv
// Directed bench for register_pair_file: writes, steps, byte/word reads, reset.
module tb_register_pair_file;
  import register_pair_file_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wr_sel, step_sel, rdA_sel, rdB_sel, wA_sel, wB_sel;
  logic        wr_l, wr_h, wr_w, inc, dec;
  logic        rdA_hi, rdA_en, rdB_hi, rdB_en;
  logic [7:0]  din_b, rdA_data, rdB_data;
  logic [15:0] din_w, wA_data, wB_data;
  logic        rdA_valid, rdB_valid, step_wrap;

  int n_checks = 0;
  int n_errors = 0;

  register_pair_file #(.BYTE_W(8), .PAIRS(4)) dut (
    .clk(clk), .rst(rst),
    .wr_sel(wr_sel), .wr_l(wr_l), .wr_h(wr_h), .wr_w(wr_w),
    .din_b(din_b), .din_w(din_w),
    .step_sel(step_sel), .inc(inc), .dec(dec),
    .rdA_sel(rdA_sel), .rdA_hi(rdA_hi), .rdA_en(rdA_en),
    .rdB_sel(rdB_sel), .rdB_hi(rdB_hi), .rdB_en(rdB_en),
    .rdA_data(rdA_data), .rdA_valid(rdA_valid),
    .rdB_data(rdB_data), .rdB_valid(rdB_valid),
    .wA_sel(wA_sel), .wB_sel(wB_sel),
    .wA_data(wA_data), .wB_data(wB_data),
    .step_wrap(step_wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wr_l = 0; wr_h = 0; wr_w = 0; inc = 0; dec = 0;
    rdA_en = 0; rdB_en = 0;
  endtask

  task automatic word_a(input logic [1:0] sel, input string tag, input logic [15:0] exp);
    wA_sel = sel;
    #1;
    chk(tag, wA_data, exp);
  endtask

  task automatic write_w(input logic [1:0] sel, input logic [15:0] w);
    wr_sel = sel; din_w = w; wr_w = 1;
    tick;
    idle;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: sim time exceeded bound");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; idle;
    wr_sel = 0; step_sel = 0; rdA_sel = 0; rdB_sel = 0; wA_sel = 0; wB_sel = 0;
    rdA_hi = 0; rdB_hi = 0; din_b = 0; din_w = 0;
    #2;
    tick; tick;
    rst = 0;

    // Reset state
    for (int i = 0; i < 4; i++) word_a(2'(i), "rst_pair", 16'h0000);
    chk("rst_rdA_valid", 16'(rdA_valid), 16'h0);
    chk("rst_rdB_valid", 16'(rdB_valid), 16'h0);
    chk("rst_rdA_data", 16'(rdA_data), 16'h0);
    chk("rst_wrap", 16'(step_wrap), 16'h0);

    // Word write then increment with carry into the high byte
    write_w(PAIR_HL, 16'h12FF);
    word_a(PAIR_HL, "hl_written", 16'h12FF);
    step_sel = PAIR_HL; inc = 1;
    tick; idle;
    word_a(PAIR_HL, "hl_inc_carry", 16'h1300);
    chk("hl_inc_wrap", 16'(step_wrap), 16'h0);

    // Byte write has priority over word write on its half
    wr_sel = PAIR_DE; wr_l = 1; wr_w = 1; din_b = 8'hAA; din_w = 16'h5566;
    tick; idle;
    wB_sel = PAIR_DE; #1;
    chk("de_mixed_write", wB_data, 16'h55AA);

    // Wrap on increment from all-ones and decrement from zero
    write_w(PAIR_SP, 16'hFFFF);
    step_sel = PAIR_SP; inc = 1;
    tick; idle;
    word_a(PAIR_SP, "sp_inc_wrap_val", 16'h0000);
    chk("sp_inc_wrap", 16'(step_wrap), 16'h1);
    tick;
    chk("sp_wrap_clears", 16'(step_wrap), 16'h0);
    dec = 1;
    tick; idle;
    word_a(PAIR_SP, "sp_dec_wrap_val", 16'hFFFF);
    chk("sp_dec_wrap", 16'(step_wrap), 16'h1);

    // Byte read returns the pre-write value, then the new one
    write_w(PAIR_BC, 16'h0102);
    rdA_en = 1; rdA_sel = PAIR_BC; rdA_hi = 1;
    wr_sel = PAIR_BC; wr_h = 1; din_b = 8'h77;
    tick;
    wr_h = 0;
    chk("rdA_old_data", 16'(rdA_data), 16'h0001);
    chk("rdA_old_valid", 16'(rdA_valid), 16'h1);
    tick; idle;
    chk("rdA_new_data", 16'(rdA_data), 16'h0077);
    tick;
    chk("rdA_idle_valid", 16'(rdA_valid), 16'h0);
    chk("rdA_idle_data", 16'(rdA_data), 16'h0000);

    // Port B low-byte read
    rdB_en = 1; rdB_sel = PAIR_DE; rdB_hi = 0;
    tick; idle;
    chk("rdB_low", 16'(rdB_data), 16'h00AA);
    chk("rdB_valid", 16'(rdB_valid), 16'h1);

    // Write to the stepped pair suppresses the step
    step_sel = PAIR_HL; inc = 1; wr_sel = PAIR_HL; wr_l = 1; din_b = 8'h05;
    tick; idle;
    word_a(PAIR_HL, "hl_step_suppressed", 16'h1305);
    chk("hl_suppress_wrap", 16'(step_wrap), 16'h0);
    inc = 1; dec = 1;
    tick; idle;
    word_a(PAIR_HL, "hl_inc_dec_hold", 16'h1305);
    chk("hl_inc_dec_wrap", 16'(step_wrap), 16'h0);

    // Decrement borrows across halves
    write_w(PAIR_HL, 16'h0100);
    dec = 1;
    tick; idle;
    word_a(PAIR_HL, "hl_dec_borrow", 16'h00FF);

    // Step and write on different pairs both execute
    wr_sel = PAIR_BC; wr_w = 1; din_w = 16'hBEEF; step_sel = PAIR_DE; inc = 1;
    tick; idle;
    word_a(PAIR_BC, "bc_parallel_write", 16'hBEEF);
    word_a(PAIR_DE, "de_parallel_inc", 16'h55AB);

    // Both byte strobes write din_b into both halves
    wr_sel = PAIR_DE; wr_l = 1; wr_h = 1; din_b = 8'h3C;
    tick; idle;
    word_a(PAIR_DE, "de_both_bytes", 16'h3C3C);

    // Reset during a read and a step
    rdA_en = 1; rdA_sel = PAIR_BC; rdA_hi = 0; step_sel = PAIR_SP; inc = 1; rst = 1;
    tick; idle; rst = 0;
    chk("rst_mid_valid", 16'(rdA_valid), 16'h0);
    chk("rst_mid_data", 16'(rdA_data), 16'h0000);
    chk("rst_mid_wrap", 16'(step_wrap), 16'h0);
    word_a(PAIR_SP, "rst_mid_sp", 16'h0000);
    word_a(PAIR_BC, "rst_mid_bc", 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/register_pair_file.md
Name: register_pair_file

Overview:
- Parametrised successor to the single 8-bit register pair.
- Holds PAIRS register pairs, each a low byte and a high byte that can also be accessed as one 2*BYTE_W word.
- Provides:
  - byte and word writes;
  - two registered byte-read ports;
  - two combinational word-read ports;
  - an increment/decrement unit that steps a whole pair (pointer/counter use).
- Sits in the CPU datapath between the 8-bit data bus and the 16-bit address bus.

Parameters:
BYTE_W, 8, width of one half-register
PAIRS, 4, number of register pairs (>=2)
PAIR_AW, $clog2(PAIRS), pair select width (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
wr_sel  in  PAIR_AW  pair targeted by writes
wr_l  in  1  write din_b into low byte of wr_sel
wr_h  in  1  write din_b into high byte of wr_sel
wr_w  in  1  write din_w into whole pair wr_sel
din_b  in  BYTE_W  byte write data
din_w  in  2*BYTE_W  word write data
step_sel  in  PAIR_AW  pair targeted by inc/dec
inc  in  1  pair step_sel += 1
dec  in  1  pair step_sel -= 1
rdA_sel, rdB_sel  in  PAIR_AW  byte-read pair select
rdA_hi, rdB_hi  in  1  0 = low byte, 1 = high byte
rdA_en, rdB_en  in  1  byte-read request
rdA_data, rdB_data  out  BYTE_W  registered byte-read data
rdA_valid, rdB_valid  out  1  registered byte-read valid
wA_sel, wB_sel  in  PAIR_AW  word-read pair select
wA_data, wB_data  out  2*BYTE_W  combinational word {high, low}
step_wrap  out  1  registered: last step wrapped

Behaviour:
- Reset is synchronous and active-high on rst, sampled at the rising edge of clk, which is the only clock.
- On reset:
  - all pairs = 0;
  - rdA/rdB_data = 0, rdA/rdB_valid = 0;
  - step_wrap = 0.
  - rst wins over every other input in the same cycle.
- Writes take effect at the edge; the new value is visible on word reads the following cycle.
- Per-half write priority on pair wr_sel:
  - low half: wr_l -> din_b; else wr_w -> din_w[BYTE_W-1:0];
  - high half: wr_h -> din_b; else wr_w -> din_w[2*BYTE_W-1:BYTE_W].
  - Example: wr_l and wr_w together = low from din_b, high from din_w.
  - wr_l and wr_h together write din_b into both halves.
- Step unit:
  - inc xor dec active -> pair step_sel = pair ± 1, modulo 2^(2*BYTE_W), with carry/borrow propagating across halves.
  - inc and dec together = no change, step_wrap <= 0.
  - A step is suppressed (pair unchanged, step_wrap <= 0) when any of wr_l/wr_h/wr_w is active and wr_sel == step_sel; the write wins.
  - step_wrap <= 1 for one cycle when an executed inc starts from all-ones or an executed dec starts from 0; otherwise <= 0 each cycle.
- Byte reads, latency 1:
  - rdX_en sampled at the edge -> next cycle rdX_valid = 1 and rdX_data = selected half as held before that edge.
  - No write-through: a read and a write to the same half in one cycle returns the old value.
  - rdX_en = 0 -> rdX_valid <= 0, rdX_data <= 0. Outputs are driven to zero, not tri-stated.
- Word reads: wX_data = {high, low} of pair wX_sel, purely combinational, current stored value.
- Out-of-range selects (PAIRS not a power of two):
  - writes and steps are ignored;
  - reads return 0, with valid still 1 for an enabled byte read.
- Reset asserted mid-step or mid-read: the next cycle shows reset values; a pending read's valid is dropped.

Decomposition:
- Shared cpu package holds: default BYTE_W = 8, the pair index constants (e.g. PAIR_BC = 0, PAIR_DE = 1, PAIR_HL = 2, PAIR_SP = 3), and a localparam WORD_W = 2*BYTE_W.
- One natural sub-module: register_pair_stepper.
  - Combinational ± 1 on a 2*BYTE_W word.
  - Outputs the result and the wrap flag.
  - Instantiated once and muxed by step_sel.

Test Plan:
- Reset, then word-read all pairs -> all 0; rdA_valid = 0; step_wrap = 0.
- Write wr_w, pair 2, din_w = 16'h12FF; next cycle inc on pair 2 -> wA_data(sel 2) = 16'h1300, step_wrap = 0.
- Same cycle: wr_l, wr_w, pair 1, din_b = 8'hAA, din_w = 16'h5566 -> pair 1 = 16'h55AA.
- Pair 3 = 16'hFFFF, inc -> 16'h0000 and step_wrap = 1 for one cycle; then dec -> 16'hFFFF, step_wrap = 1.
- Pair 0 = 16'h0102; same cycle: rdA_en on pair 0 with rdA_hi = 1, and wr_h to pair 0 with din_b = 8'h77 -> next cycle rdA_data = 8'h01 with valid 1; a second read the following cycle returns 8'h77.
- Same cycle: inc on pair 2 and wr_l on pair 2 with din_b = 8'h05 -> step suppressed, low byte = 05, high byte unchanged. Then inc and dec together -> pair unchanged.
